// File: rtl/fifo_pkg.sv
// Shared defaults and pointer arithmetic for the transactional FIFO.
// Pointers carry one extra wrap bit, and all differences are taken modulo 2^(ADDR+1).
package fifo_pkg;

    localparam int DEF_ADDR      = 4;
    localparam int DEF_WIDTH     = 32;
    localparam int DEF_AF_THRESH = 2;
    localparam int DEF_AE_THRESH = 2;

    // Difference a - b taken modulo 2^ptr_w. The caller narrows the result to its pointer width.
    function automatic logic [31:0] ptr_diff(input logic [31:0] a, input logic [31:0] b,
                                             input int ptr_w);
        return (a - b) & ((32'd1 << ptr_w) - 32'd1);
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port RAM with one write port and one registered read port.
// Only the output register is reset; the array itself is never reset.
module fifo_ram #(
    parameter int ADDR  = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [ADDR-1:0]  waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [ADDR-1:0]  raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [2**ADDR];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sync_txn_fifo.sv
// Single-clock FIFO where each side keeps a working pointer and a committed pointer.
// The reader sees only committed writes, and the writer gets back only committed reads.
module sync_txn_fifo
    import fifo_pkg::*;
#(
    parameter int ADDR      = DEF_ADDR,
    parameter int WIDTH     = DEF_WIDTH,
    parameter int AF_THRESH = DEF_AF_THRESH,
    parameter int AE_THRESH = DEF_AE_THRESH
) (
    input  logic             clk,
    input  logic             rst_clk_n,
    input  logic             write_en,
    input  logic [WIDTH-1:0] write_data,
    input  logic             snap_wraddr,
    input  logic             roll_wraddr,
    input  logic             read_en,
    input  logic             snap_rdaddr,
    input  logic             roll_rdaddr,
    output logic [WIDTH-1:0] read_data,
    output logic             read_valid,
    output logic             fifo_full,
    output logic             fifo_empty,
    output logic [ADDR:0]    room_avail,
    output logic [ADDR:0]    data_avail,
    output logic             almost_full,
    output logic             almost_empty,
    output logic             overflow,
    output logic             underflow
);

    localparam int            P     = ADDR + 1;
    localparam logic [P-1:0]  DEPTH = P'(2**ADDR);

    logic [P-1:0] wr_ptr, wr_cmt, rd_ptr, rd_cmt;
    logic [P-1:0] wr_ptr_nxt, rd_ptr_nxt;
    logic         wr_acc, rd_acc;

    assign room_avail   = DEPTH - P'(ptr_diff(32'(wr_ptr), 32'(rd_cmt), P));
    assign data_avail   = P'(ptr_diff(32'(wr_cmt), 32'(rd_ptr), P));
    assign fifo_full    = (room_avail == '0);
    assign fifo_empty   = (data_avail == '0);
    assign almost_full  = (room_avail <= P'(AF_THRESH));
    assign almost_empty = (data_avail <= P'(AE_THRESH));

    // A roll blocks any access on its side in the same cycle.
    assign wr_acc     = !roll_wraddr && write_en && !fifo_full;
    assign rd_acc     = !roll_rdaddr && read_en && !fifo_empty;
    assign wr_ptr_nxt = wr_acc ? wr_ptr + P'(1) : wr_ptr;
    assign rd_ptr_nxt = rd_acc ? rd_ptr + P'(1) : rd_ptr;

    always_ff @(posedge clk or negedge rst_clk_n) begin
        if (!rst_clk_n) begin
            wr_ptr   <= '0;
            wr_cmt   <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= write_en && !roll_wraddr && fifo_full;
            if (roll_wraddr) begin
                wr_ptr <= wr_cmt;
            end else begin
                wr_ptr <= wr_ptr_nxt;
                if (snap_wraddr) begin
                    wr_cmt <= wr_ptr_nxt;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_clk_n) begin
        if (!rst_clk_n) begin
            rd_ptr     <= '0;
            rd_cmt     <= '0;
            read_valid <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            read_valid <= rd_acc;
            underflow  <= read_en && !roll_rdaddr && fifo_empty;
            if (roll_rdaddr) begin
                rd_ptr <= rd_cmt;
            end else begin
                rd_ptr <= rd_ptr_nxt;
                if (snap_rdaddr) begin
                    rd_cmt <= rd_ptr_nxt;
                end
            end
        end
    end

    fifo_ram #(
        .ADDR  (ADDR),
        .WIDTH (WIDTH)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_clk_n),
        .we    (wr_acc),
        .waddr (wr_ptr[ADDR-1:0]),
        .wdata (write_data),
        .re    (rd_acc),
        .raddr (rd_ptr[ADDR-1:0]),
        .rdata (read_data)
    );

endmodule
